// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and FSM encoding for the ALU scheduler
package alu_pkg;

   localparam int WIDTH = 4;
   localparam int OPW   = 3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - requester and response handshake bundle for alu_sched
interface alu_sched_if import alu_pkg::*; #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int OPW   = alu_pkg::OPW
);

   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_out;
   logic             rsp_carry;

   logic             busy;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_out, rsp_carry,
      output rsp_ready,
      input  busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_out, rsp_carry,
      input  rsp_ready,
      output busy
   );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 8-operation ALU with carry/borrow/shift-out bit
module alu_core import alu_pkg::*; #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int OPW   = alu_pkg::OPW
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   op,
   output logic [WIDTH-1:0] out,
   output logic             carry
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   // One extra bit on both so the top bit is carry-out for add and borrow for sub
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   // Opcode decode; logic ops leave carry at its zero default
   always_comb begin
      out   = '0;
      carry = 1'b0;
      case (op)
         OP_ADD: begin
            out   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
         end
         OP_SUB: begin
            out   = diff[WIDTH-1:0];
            carry = diff[WIDTH];
         end
         OP_AND: out = a & b;
         OP_OR:  out = a | b;
         OP_XOR: out = a ^ b;
         OP_NOT: out = ~a;
         OP_SHL: begin
            out   = {a[WIDTH-2:0], 1'b0};
            carry = a[WIDTH-1];
         end
         OP_SHR: begin
            out   = {1'b0, a[WIDTH-1:1]};
            carry = a[0];
         end
         default: begin
            out   = '0;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin two-requester scheduler driving a shared ALU
module alu_sched import alu_pkg::*; #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int OPW   = alu_pkg::OPW
) (
   input  logic        clk,
   input  logic        rst,
   alu_sched_if.slave  bus
);

   state_t           state;
   state_t           state_nxt;
   logic             ptr;
   logic             gnt_any;
   logic             gnt_id;
   logic             accept;

   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic [OPW-1:0]   lat_op;
   logic             lat_id;

   logic [WIDTH-1:0] alu_out;
   logic             alu_carry;

   logic [WIDTH-1:0] rsp_out_q;
   logic             rsp_carry_q;
   logic             rsp_id_q;

   // Grant selection: pointer only breaks ties, a lone valid always wins
   always_comb begin
      gnt_any = bus.req0_valid | bus.req1_valid;
      gnt_id  = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         gnt_id = ptr;
      end else begin
         gnt_id = bus.req1_valid;
      end
   end

   // Next-state logic; accepting only happens from IDLE and never during reset
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (gnt_any && !rst) begin
               accept    = 1'b1;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand capture on accept, result capture in EXEC, pointer advance on grant
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= 1'b0;
         lat_a       <= '0;
         lat_b       <= '0;
         lat_op      <= '0;
         lat_id      <= 1'b0;
         rsp_out_q   <= '0;
         rsp_carry_q <= 1'b0;
         rsp_id_q    <= 1'b0;
      end else begin
         if (accept) begin
            lat_a  <= gnt_id ? bus.req1_a  : bus.req0_a;
            lat_b  <= gnt_id ? bus.req1_b  : bus.req0_b;
            lat_op <= gnt_id ? bus.req1_op : bus.req0_op;
            lat_id <= gnt_id;
            ptr    <= ~gnt_id;
         end
         if (state == ST_EXEC) begin
            rsp_out_q   <= alu_out;
            rsp_carry_q <= alu_carry;
            rsp_id_q    <= lat_id;
         end
      end
   end

   alu_core #(
      .WIDTH (WIDTH),
      .OPW   (OPW)
   ) u_alu_core (
      .a     (lat_a),
      .b     (lat_b),
      .op    (lat_op),
      .out   (alu_out),
      .carry (alu_carry)
   );

   assign bus.req0_ready = accept && !gnt_id;
   assign bus.req1_ready = accept &&  gnt_id;
   assign bus.rsp_valid  = (state == ST_RESP);
   assign bus.rsp_out    = rsp_out_q;
   assign bus.rsp_carry  = rsp_carry_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.busy       = (state != ST_IDLE);

endmodule
